conv_relu_pool_engine: RTL and testbench

- Parametrised 3x3 convolution engine over an IMG_DIM x IMG_DIM grayscale image in external image ROM.
- Applies zero padding, fixed kernel, bias, round-to-nearest and saturation, then ReLU; writes the result to layer-0 memory.
- Then performs 2x2 stride-2 max-pooling from layer 0 into layer-1 memory.
- Sits between the host image ROM and the shared layer-0/layer-1 SRAMs; host handshake is `ready`/`busy`.

---
 rtl/conv_pkg.sv | 50 +++++
 rtl/conv_relu_pool_engine_mac.sv | 77 +++++++
 rtl/conv_relu_pool_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_conv_relu_pool_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the conv_relu_pool_engine slice:
//     - KERNEL       : fixed 3x3 coefficients, row-major, signed Q3.16 (20 bit)
//     - DEFAULT_BIAS : bias added before rounding, same format as the data
//     - CSEL_*       : layer memory select encodings
//     - state_t      : engine FSM states
//     - tap_dr/tap_dc: row/column offset (+1) of 3x3 tap k
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam logic [19:0] DEFAULT_BIAS = 20'h01310;

    localparam logic [19:0] KERNEL [0:8] = '{
        20'h0A98E, 20'h092D5, 20'h06D43,
        20'h01004, 20'hF8F71, 20'hF6E54,
        20'hFA6D7, 20'hFC834, 20'hFAC19
    };

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC_TAIL,
        ST_WR_L0,
        ST_RD_L0,
        ST_CMP_TAIL,
        ST_WR_L1,
        ST_DONE
    } state_t;

    // Offsets are returned biased by +1 (0..2) so callers stay unsigned.
    function automatic logic [1:0] tap_dr(input logic [3:0] k);
        if (k < 4'd3)      return 2'd0;
        else if (k < 4'd6) return 2'd1;
        else               return 2'd2;
    endfunction

    function automatic logic [1:0] tap_dc(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/conv_relu_pool_engine_mac.sv
// ---------------------------------------------------------------------------
// conv_mac
//   Multiply-accumulate datapath for one 3x3 output pixel, followed by bias,
//   round-to-nearest, saturation to signed DATA_W and ReLU.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     clear           zero the accumulator (has priority over acc_en)
//     acc_en          add operand*coef to the accumulator this cycle
//     operand, coef   signed DATA_W fixed-point factors
//     result          ReLU(saturate((acc + bias + half) >>> FRAC_W)), combinational
// ---------------------------------------------------------------------------
module conv_mac #(
    parameter int                DATA_W = 20,
    parameter int                FRAC_W = 16,
    parameter logic [DATA_W-1:0] BIAS   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] coef,
    output logic [DATA_W-1:0] result
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + 4;
    localparam int EXT_W  = ACC_W - DATA_W - FRAC_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  bias_term;
    logic signed [ACC_W-1:0]  round_term;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic        [DATA_W-1:0] sat;

    // Operands are sign-extended to the product width so the truncated
    // product is the exact signed result.
    assign prod = $signed({{DATA_W{operand[DATA_W-1]}}, operand}) *
                  $signed({{DATA_W{coef[DATA_W-1]}}, coef});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    // Bias is aligned to the product scale; adding half an LSB before the
    // arithmetic shift gives round-half-up.
    assign bias_term  = {{EXT_W{BIAS[DATA_W-1]}}, BIAS, {FRAC_W{1'b0}}};
    assign round_term = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    assign sum        = acc_q + bias_term + round_term;
    assign shifted    = sum >>> FRAC_W;

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

    assign result = sat[DATA_W-1] ? '0 : sat;

endmodule

// File: rtl/conv_relu_pool_engine.sv
// ---------------------------------------------------------------------------
// conv_relu_pool_engine
//   3x3 zero-padded convolution + bias + round + saturate + ReLU over an
//   IMG_DIM x IMG_DIM image in external ROM, written to layer-0 memory,
//   followed by 2x2 stride-2 max pooling from layer 0 into layer 1.
//   Build option: define CONV_POOL_EN to include the pooling phase; without
//   it the engine finishes after the last layer-0 write.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     ready                 host start request (image ROM valid)
//     idata                 ROM data, valid the cycle after iaddr
//     cdata_rd              layer memory read data, valid the cycle after crd
//     busy                  high from start until the final write completes
//     iaddr                 ROM address, row-major
//     cwr/caddr_wr/cdata_wr layer memory write strobe, address, data
//     crd/caddr_rd          layer memory read strobe, address
//     csel                  memory select: 000 none, 001 layer 0, 011 layer 1
//
//   Host handshake: ready is sampled only while the engine is idle
//   (busy=0); a sampled 1 starts a frame and busy rises on the next cycle.
//   While busy=1 ready is ignored. There is no back-pressure on any memory
//   port: reads return data exactly one cycle after the strobe.
// ---------------------------------------------------------------------------
module conv_relu_pool_engine
    import conv_pkg::*;
#(
    parameter int                IMG_DIM = 64,
    parameter int                DATA_W  = 20,
    parameter int                FRAC_W  = 16,
    parameter logic [DATA_W-1:0] BIAS    = DEFAULT_BIAS,
    localparam int               ADDR_W  = 2 * $clog2(IMG_DIM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATA_W-1:0] idata,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [2:0]        csel
);

    localparam int            RC_W    = $clog2(IMG_DIM);
    localparam logic [RC_W:0] DIM_EXT = (RC_W+1)'(IMG_DIM);

    state_t state_q, state_d;

    logic [RC_W-1:0]   r_q, c_q;
    logic [3:0]        k_q;
    logic              raster_last;
    logic [RC_W:0]     tap_r, tap_c;
    logic              tap_ok;
    logic [ADDR_W-1:0] tap_addr;
    logic [ADDR_W-1:0] iaddr_hold_q;

    logic              mac_en_q;
    logic              tap_ok_q;
    logic [3:0]        mac_k_q;
    logic              acc_clear;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] mac_result;

    assign raster_last = (r_q == RC_W'(IMG_DIM-1)) && (c_q == RC_W'(IMG_DIM-1));

    // Tap coordinates carry a +1 bias so row/col -1 is 0 and row/col
    // IMG_DIM is the upper out-of-range value; both are padding.
    assign tap_r    = {1'b0, r_q} + {{(RC_W-1){1'b0}}, tap_dr(k_q)};
    assign tap_c    = {1'b0, c_q} + {{(RC_W-1){1'b0}}, tap_dc(k_q)};
    assign tap_ok   = (tap_r != '0) && (tap_r <= DIM_EXT) &&
                      (tap_c != '0) && (tap_c <= DIM_EXT);
    assign tap_addr = {tap_r[RC_W-1:0] - RC_W'(1), tap_c[RC_W-1:0] - RC_W'(1)};

`ifdef CONV_POOL_EN
    localparam int P_W = RC_W - 1;

    logic [P_W-1:0]    i_q, j_q;
    logic [1:0]        q_q;
    logic              rd_fold_q;
    logic              rd_first_q;
    logic [DATA_W-1:0] max_q;
    logic              pool_last;

    assign pool_last = (i_q == '1) && (j_q == '1);
`else
    logic unused_rd;
    assign unused_rd = ^cdata_rd;
`endif

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != ST_IDLE);
        iaddr    = iaddr_hold_q;
        cwr      = 1'b0;
        crd      = 1'b0;
        csel     = CSEL_NONE;
        caddr_wr = '0;
        cdata_wr = '0;
        caddr_rd = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ready) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Padding taps keep the previous address on the bus.
                if (tap_ok) iaddr = tap_addr;
                if (k_q == 4'd8) state_d = ST_MAC_TAIL;
            end
            ST_MAC_TAIL: begin
                state_d = ST_WR_L0;
            end
            ST_WR_L0: begin
                cwr      = 1'b1;
                csel     = CSEL_L0;
                caddr_wr = {r_q, c_q};
                cdata_wr = mac_result;
`ifdef CONV_POOL_EN
                state_d  = raster_last ? ST_RD_L0 : ST_LOAD;
`else
                state_d  = raster_last ? ST_DONE : ST_LOAD;
`endif
            end
`ifdef CONV_POOL_EN
            ST_RD_L0: begin
                crd      = 1'b1;
                csel     = CSEL_L0;
                caddr_rd = {i_q, q_q[1], j_q, q_q[0]};
                if (q_q == 2'd3) state_d = ST_CMP_TAIL;
            end
            ST_CMP_TAIL: begin
                state_d = ST_WR_L1;
            end
            ST_WR_L1: begin
                cwr      = 1'b1;
                csel     = CSEL_L1;
                caddr_wr = {2'b00, i_q, j_q};
                cdata_wr = max_q;
                state_d  = pool_last ? ST_DONE : ST_RD_L0;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- convolution counters and MAC pipeline ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            iaddr_hold_q <= '0;
            mac_en_q     <= 1'b0;
            tap_ok_q     <= 1'b0;
            mac_k_q      <= '0;
        end else begin
            iaddr_hold_q <= iaddr;
            // Tap k's ROM word arrives next cycle; its MAC controls follow it.
            mac_en_q     <= (state_q == ST_LOAD);
            tap_ok_q     <= (state_q == ST_LOAD) && tap_ok;
            mac_k_q      <= k_q;
            case (state_q)
                ST_IDLE: begin
                    r_q <= '0;
                    c_q <= '0;
                    k_q <= '0;
                end
                ST_LOAD: begin
                    k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
                end
                ST_WR_L0: begin
                    // Wraps to (0,0) after the last pixel.
                    c_q <= c_q + RC_W'(1);
                    if (c_q == RC_W'(IMG_DIM-1)) r_q <= r_q + RC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign acc_clear = (state_q == ST_IDLE) || ((state_q == ST_LOAD) && (k_q == 4'd0));
    assign operand   = tap_ok_q ? idata : '0;

    conv_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .BIAS   (BIAS)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .acc_en  (mac_en_q),
        .operand (operand),
        .coef    (KERNEL[mac_k_q]),
        .result  (mac_result)
    );

`ifdef CONV_POOL_EN
    // ---------------- pooling counters and running max ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q        <= '0;
            j_q        <= '0;
            q_q        <= '0;
            rd_fold_q  <= 1'b0;
            rd_first_q <= 1'b0;
            max_q      <= '0;
        end else begin
            rd_fold_q  <= (state_q == ST_RD_L0);
            rd_first_q <= (state_q == ST_RD_L0) && (q_q == 2'd0);
            // Read data lags the strobe by one cycle, so the fold of read q
            // happens in the cycle after it was issued.
            if (rd_fold_q) begin
                if (rd_first_q || ($signed(cdata_rd) > $signed(max_q))) begin
                    max_q <= cdata_rd;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    i_q <= '0;
                    j_q <= '0;
                    q_q <= '0;
                end
                ST_RD_L0: begin
                    q_q <= q_q + 2'd1;
                end
                ST_WR_L1: begin
                    j_q <= j_q + P_W'(1);
                    if (j_q == '1) i_q <= i_q + P_W'(1);
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_conv_relu_pool_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_relu_pool_engine
//   Bench for conv_relu_pool_engine at IMG_DIM=16. Provides the image ROM and
//   layer memories, computes every expected layer-0 / layer-1 word directly
//   from the convolution / pooling definition, and compares each DUT write
//   in order. Honours CONV_POOL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_conv_relu_pool_engine;

    localparam int N      = 16;
    localparam int NP     = N / 2;
    localparam int DATA_W = 20;
    localparam int FRAC_W = 16;
    localparam int ADDR_W = 2 * $clog2(N);
    localparam int EXP_W  = 3 + ADDR_W + DATA_W;
    localparam logic [DATA_W-1:0] BIAS_V = 20'h01310;
`ifdef CONV_POOL_EN
    localparam int POOL = 1;
`else
    localparam int POOL = 0;
`endif
    // Busy covers every LOAD..WR cycle of both phases plus the DONE cycle.
    localparam int EXP_BUSY = 11 * N * N + 6 * NP * NP * POOL + 1;

    localparam logic [DATA_W-1:0] KTAB [0:8] = '{
        20'h0A98E, 20'h092D5, 20'h06D43,
        20'h01004, 20'hF8F71, 20'hF6E54,
        20'hFA6D7, 20'hFC834, 20'hFAC19
    };

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              ready;
    logic [DATA_W-1:0] idata;
    logic [DATA_W-1:0] cdata_rd;
    logic              busy;
    logic [ADDR_W-1:0] iaddr;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [2:0]        csel;

    always #5 clk = ~clk;

    conv_relu_pool_engine #(
        .IMG_DIM (N),
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .BIAS    (BIAS_V)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .idata    (idata),
        .cdata_rd (cdata_rd),
        .busy     (busy),
        .iaddr    (iaddr),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .csel     (csel)
    );

    // ---------------- memories ----------------
    logic [DATA_W-1:0] rom    [N*N];
    logic [DATA_W-1:0] l0_mem [N*N];
    logic [DATA_W-1:0] l1_mem [N*N];

    initial begin
        idata    = '0;
        cdata_rd = '0;
    end

    always @(posedge clk) begin
        idata <= rom[iaddr];
        if (crd && csel == 3'b001) cdata_rd <= l0_mem[caddr_rd];
        if (cwr && csel == 3'b001) l0_mem[caddr_wr] <= cdata_wr;
        if (cwr && csel == 3'b011) l1_mem[caddr_wr] <= cdata_wr;
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] exp_l0 [N*N];
    logic [DATA_W-1:0] exp_l1 [NP*NP];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic longint sx(input logic [DATA_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [DATA_W-1:0] model_pixel(input int r, input int c);
        longint acc;
        int     k;
        acc = 0;
        k   = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < N && c + dc >= 0 && c + dc < N)
                    acc += sx(rom[(r + dr) * N + c + dc]) * sx(KTAB[k]);
                k++;
            end
        end
        acc = acc + (sx(BIAS_V) <<< FRAC_W) + (longint'(1) <<< (FRAC_W - 1));
        acc = acc >>> FRAC_W;
        if (acc > 524287)  acc = 524287;
        if (acc < -524288) acc = -524288;
        if (acc < 0)       acc = 0;
        return acc[DATA_W-1:0];
    endfunction

    task automatic build_expect();
        logic [DATA_W-1:0] m;
        exp_q.delete();
        for (int p = 0; p < N * N; p++) begin
            exp_l0[p] = model_pixel(p / N, p % N);
            exp_q.push_back({3'b001, ADDR_W'(p), exp_l0[p]});
        end
        if (POOL == 1) begin
            for (int i = 0; i < NP; i++) begin
                for (int j = 0; j < NP; j++) begin
                    m = exp_l0[(2*i) * N + 2*j];
                    if ($signed(exp_l0[(2*i) * N + 2*j + 1]) > $signed(m)) m = exp_l0[(2*i) * N + 2*j + 1];
                    if ($signed(exp_l0[(2*i+1) * N + 2*j]) > $signed(m)) m = exp_l0[(2*i+1) * N + 2*j];
                    if ($signed(exp_l0[(2*i+1) * N + 2*j + 1]) > $signed(m)) m = exp_l0[(2*i+1) * N + 2*j + 1];
                    exp_l1[i * NP + j] = m;
                    exp_q.push_back({3'b011, ADDR_W'(i * NP + j), m});
                end
            end
        end
    endtask

    // Compare process: every write against the expected queue, plus the
    // strobe/select invariants every cycle.
    always @(negedge clk) begin
        logic [EXP_W-1:0] front;
        check("strobe_invariant",
              64'({cwr && crd, !cwr && !crd && csel != 3'b000, POOL == 0 && csel == 3'b011}),
              64'(0));
        if (cwr) begin
            if (exp_q.size() == 0) begin
                check("write_unexpected", 64'({csel, caddr_wr, cdata_wr}), 64'(0));
            end else begin
                front = exp_q.pop_front();
                check("write", 64'({csel, caddr_wr, cdata_wr}), 64'(front));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] all_outputs();
        return 64'({busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel});
    endfunction

    task automatic fill_random();
        for (int a = 0; a < N * N; a++) begin
            if ($urandom_range(0, 1) == 1) rom[a] = DATA_W'($urandom());
            else rom[a] = DATA_W'($urandom_range(0, 'h1FFFF)) - 20'h10000;
        end
    endtask

    task automatic run_image(input bit toggle_ready);
        int cnt;
        bit done;
        build_expect();
        @(negedge clk);
        ready = 1'b1;
        cnt   = 0;
        done  = 1'b0;
        for (int t = 0; t < EXP_BUSY + 200 && !done; t++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                ready = toggle_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                ready = 1'b0;
                done  = 1'b1;
            end
        end
        check("busy_done", 64'(done), 64'(1));
        check("busy_cycles", 64'(cnt), 64'(EXP_BUSY));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        ready = 1'b0;
        for (int a = 0; a < N * N; a++) begin
            rom[a]    = '0;
            l0_mem[a] = '0;
            l1_mem[a] = '0;
        end
        #12;
        check("reset_outputs", all_outputs(), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All-zero image: every word is the bias alone.
        run_image(1'b0);
        check("zero_model_l0", 64'(exp_l0[37]), 64'h01310);
        check("zero_l0_first", 64'(l0_mem[0]), 64'h01310);
        check("zero_l0_last", 64'(l0_mem[N*N-1]), 64'h01310);
        if (POOL == 1) check("zero_l1_0", 64'(l1_mem[0]), 64'h01310);

        // Single unit pixel at (0,0): each neighbour sees one kernel tap.
        rom[0] = 20'h10000;
        run_image(1'b0);
        check("pix_model_0", 64'(exp_l0[0]), 64'h0);
        check("pix_model_1", 64'(exp_l0[1]), 64'h02314);
        check("pix_l0_0", 64'(l0_mem[0]), 64'h0);
        check("pix_l0_1", 64'(l0_mem[1]), 64'h02314);
        check("pix_l0_n", 64'(l0_mem[N]), 64'h0A5E5);
        check("pix_l0_n1", 64'(l0_mem[N+1]), 64'h0BC9E);
        if (POOL == 1) check("pix_l1_0", 64'(l1_mem[0]), 64'h0BC9E);

        // Row 0 at positive full scale: row 1 saturates without wrapping.
        for (int a = 0; a < N * N; a++) rom[a] = (a < N) ? 20'h7FFFF : 20'h0;
        run_image(1'b0);
        check("sat_model", 64'(exp_l0[N+3]), 64'h7FFFF);
        for (int c = 0; c < N; c++) check("sat_row0", 64'(l0_mem[c]), 64'h0);
        for (int c = 1; c < N - 1; c++) check("sat_row1", 64'(l0_mem[N+c]), 64'h7FFFF);

        // Random image with ready toggling throughout the frame.
        fill_random();
        run_image(1'b1);

        // Reset in the middle of pixel 100's LOAD, then a full rerun.
        fill_random();
        build_expect();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (11 * 100 + 3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("abort_outputs", all_outputs(), 64'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_idle", all_outputs(), 64'(0));
        run_image(1'b0);

        // One more random frame.
        fill_random();
        run_image(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
